shift_reg_n: RTL and testbench
==============================

# shift_reg_n

Parametrised synchronous shift register: the successor to the fixed 8-bit load/shift register in the CPU datapath. Parallel-loads a low field, clears the upper bits, and shifts in either direction with a selectable fill bit. Shifts run as single steps or as a counted multi-shift sequence with a busy/done handshake. Serves the serial I/O and barrel-free shift paths of the core.

## Interface
- WIDTH, 8, register width in bits (≥2)
- LOAD_W, 4, parallel-load field width (1..WIDTH); loads q[LOAD_W-1:0]
- CW, $clog2(WIDTH+1), shift-amount width (derived, not overridden)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- load  in  1  parallel load strobe (highest priority)
- load_data  in  LOAD_W  value for low field
- shift_en  in  1  single-step shift request (idle only)
- start  in  1  begin counted multi-shift (idle only)
- amount  in  CW  number of shifts for start
- dir  in  1  0 = toward MSB (q[i]<=q[i-1]); 1 = toward LSB
- serial_in  in  1  fill bit
- rotate  in  1  rotate mode (present only with SHIFT_REG_ROTATE_EN)
- q  out  WIDTH  register contents
- serial_out  out  1  last bit shifted out
- busy  out  1  multi-shift in progress
- done  out  1  one-cycle pulse at end of multi-shift

## Operation
- Reset: q=0, serial_out=0, busy=0, done=0, state IDLE, counter 0.
- Load: q <= {0, load_data}; upper WIDTH-LOAD_W bits cleared; serial_out unchanged. Abort any multi-shift: state IDLE, busy=0, no done.
- Single step (IDLE, shift_en, no load/start): one shift per edge while held.
- Shift up: out bit = q[WIDTH-1], q[0] <= fill. Shift down: out bit = q[0], q[WIDTH-1] <= fill. serial_out <= out bit.
- Fill = serial_in (or out bit when rotating, see Configuration).
- FSM states IDLE, SHIFT.
  - IDLE + start, amount>0: latch amount and dir, -> SHIFT, busy=1; no shift on this edge.
  - IDLE + start, amount=0: stay IDLE, done=1 next cycle, no shift.
  - SHIFT: one shift per edge using latched dir; serial_in/rotate sampled live each edge; counter decrements; on the edge where counter goes 1->0: -> IDLE, busy=0, done=1 for one cycle.
- Priority: load > start > shift_en. start and shift_en ignored while busy. amount > WIDTH allowed (shifts fully execute).

## Timing
- Single step: q updates at the edge sampling shift_en (1-cycle latency).
- Multi-shift of N: start sampled at edge 0; shifts at edges 1..N; busy high cycles 1..N; done high cycle N+1, coincident with busy low. New start accepted in the done cycle.
- Async reset mid-SHIFT: immediate return to reset values; no done.

## Configuration
- SHIFT_REG_ROTATE_EN defined: rotate port exists; rotate=1 makes fill = bit shifted out (circular rotate in either direction).
- Undefined: no rotate port; fill always serial_in.

## Structure
- Package shift_reg_pkg: state enum (IDLE, SHIFT), DIR_UP/DIR_DOWN constants.
- Sub-module shift_reg_ctl: FSM plus down-counter, producing step, step_dir, busy, done; datapath stays in shift_reg_n.

## Test plan
(WIDTH=8, LOAD_W=4)
- Load 4'hB -> q=8'h0B; three shift_en cycles, dir=0, serial_in=0 -> q=8'h58, serial_out=0.
- Load 4'hB; start amount=5, dir=0, serial_in=1 -> busy 5 cycles, q=8'h7F, serial_out=1, done pulse in cycle 6.
- Load 4'hB; start amount=2, dir=1, serial_in=0 -> q=8'h02, serial_out=1; amount=0 -> done next cycle, q unchanged, busy never high.
- start amount=8; after 3 shifts assert load 4'h6 -> q=8'h06, busy=0, no done; assert reset mid-SHIFT -> all outputs 0 immediately.
- Macro on: load 4'h9, rotate=1, amount=8 -> q=8'h09 at done; macro off, serial_in=0 -> q=8'h00.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared types for the parametrised shift register: controller states and
// shift-direction encodings.
package shift_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic DIR_UP   = 1'b0;  // q[i] <= q[i-1], MSB falls out
    localparam logic DIR_DOWN = 1'b1;  // q[i] <= q[i+1], LSB falls out

endpackage

// File: rtl/shift_reg_ctl.sv
// Controller for shift_reg_n: IDLE/SHIFT FSM with a down-counter for counted
// multi-shifts. Emits a per-edge step strobe and the direction to use.
module shift_reg_ctl
    import shift_reg_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          start,
    input  logic          shift_en,
    input  logic [CW-1:0] amount,
    input  logic          dir,
    output logic          step,
    output logic          step_dir,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          dir_q,   dir_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    // NOTE: every next-state signal gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (load) begin
            // A load aborts any sequence silently: no done pulse.
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (amount != '0) begin
                            state_d = SHIFT;
                            cnt_d   = amount;
                            dir_d   = dir;
                            busy_d  = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Single steps only from IDLE and only when neither load nor start wins.
    assign step     = !load && ((state_q == SHIFT) ||
                                (state_q == IDLE && !start && shift_en));
    assign step_dir = (state_q == SHIFT) ? dir_q : dir;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: rtl/shift_reg_n.sv
// Parametrised load/shift register with counted multi-shift handshake.
// Optional circular rotate mode under macro SHIFT_REG_ROTATE_EN.
module shift_reg_n
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int LOAD_W = 4,
    localparam int CW     = $clog2(WIDTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [LOAD_W-1:0] load_data,
    input  logic              shift_en,
    input  logic              start,
    input  logic [CW-1:0]     amount,
    input  logic              dir,
    input  logic              serial_in,
`ifdef SHIFT_REG_ROTATE_EN
    input  logic              rotate,
`endif
    output logic [WIDTH-1:0]  q,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    logic             step;
    logic             step_dir;
    logic             out_bit;
    logic             fill;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sout_q, sout_d;

    shift_reg_ctl #(
        .CW (CW)
    ) u_ctl (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .start    (start),
        .shift_en (shift_en),
        .amount   (amount),
        .dir      (dir),
        .step     (step),
        .step_dir (step_dir),
        .busy     (busy),
        .done     (done)
    );

    assign out_bit = (step_dir == DIR_UP) ? data_q[WIDTH-1] : data_q[0];
`ifdef SHIFT_REG_ROTATE_EN
    assign fill = rotate ? out_bit : serial_in;
`else
    assign fill = serial_in;
`endif

    always_comb begin
        data_d = data_q;
        sout_d = sout_q;
        if (load) begin
            data_d               = '0;
            data_d[LOAD_W-1:0]   = load_data;
        end else if (step) begin
            sout_d = out_bit;
            if (step_dir == DIR_UP) begin
                data_d = {data_q[WIDTH-2:0], fill};
            end else begin
                data_d = {fill, data_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            sout_q <= 1'b0;
        end else begin
            data_q <= data_d;
            sout_q <= sout_d;
        end
    end

    assign q          = data_q;
    assign serial_out = sout_q;

endmodule

// File: tb/tb_shift_reg_n.sv
// Self-checking bench for shift_reg_n (WIDTH=8, LOAD_W=4): directed scenarios
// with literal expectations plus randomized traffic against a behavioural model.
module tb_shift_reg_n;

    localparam int WIDTH  = 8;
    localparam int LOAD_W = 4;
    localparam int CW     = $clog2(WIDTH + 1);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              load = 1'b0;
    logic [LOAD_W-1:0] load_data = '0;
    logic              shift_en = 1'b0;
    logic              start = 1'b0;
    logic [CW-1:0]     amount = '0;
    logic              dir = 1'b0;
    logic              serial_in = 1'b0;
    logic              rotate = 1'b0;
    logic [WIDTH-1:0]  q;
    logic              serial_out;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    shift_reg_n #(
        .WIDTH  (WIDTH),
        .LOAD_W (LOAD_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_data  (load_data),
        .shift_en   (shift_en),
        .start      (start),
        .amount     (amount),
        .dir        (dir),
        .serial_in  (serial_in),
`ifdef SHIFT_REG_ROTATE_EN
        .rotate     (rotate),
`endif
        .q          (q),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Behavioural model: register value as an integer, plus the number of
    // shifts still owed by an accepted multi-shift request.
    int m_val;
    int m_sout;
    int m_left;
    int m_dir;
    int m_done;

    function automatic void model_reset();
        m_val  = 0;
        m_sout = 0;
        m_left = 0;
        m_dir  = 0;
        m_done = 0;
    endfunction

    function automatic void model_shift(input int d);
        int ob;
        int f;
        int rot;
`ifdef SHIFT_REG_ROTATE_EN
        rot = int'(rotate);
`else
        rot = 0;
`endif
        if (d == 0) begin
            ob    = (m_val / (1 << (WIDTH - 1))) % 2;
            f     = rot ? ob : int'(serial_in);
            m_val = (m_val * 2 + f) % (1 << WIDTH);
        end else begin
            ob    = m_val % 2;
            f     = rot ? ob : int'(serial_in);
            m_val = m_val / 2 + f * (1 << (WIDTH - 1));
        end
        m_sout = ob;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    function automatic void model_edge();
        m_done = 0;
        if (load) begin
            m_val  = int'(load_data);
            m_left = 0;
        end else if (m_left > 0) begin
            model_shift(m_dir);
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1;
        end else if (start) begin
            if (amount == 0) begin
                m_done = 1;
            end else begin
                m_left = int'(amount);
                m_dir  = int'(dir);
            end
        end else if (shift_en) begin
            model_shift(int'(dir));
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("q", 32'(q), 32'(m_val));
        check("serial_out", 32'(serial_out), 32'(m_sout));
        check("busy", 32'(busy), 32'(m_left > 0));
        check("done", 32'(done), 32'(m_done));
    endtask

    // One clock: model consumes the driven inputs, DUT sampled 1ns after the edge.
    task automatic tick();
        if (!reset) model_edge();
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        load      = 1'b0;
        shift_en  = 1'b0;
        start     = 1'b0;
        amount    = '0;
        rotate    = 1'b0;
    endtask

    task automatic do_load(input logic [LOAD_W-1:0] v);
        idle_inputs();
        load      = 1'b1;
        load_data = v;
        tick();
        load      = 1'b0;
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare();
        @(posedge clock);
        #1;
        reset = 1'b0;
        compare();
    endtask

    int bc;
    int done_at;
    int saw_done;

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare();
        check("reset_q", 32'(q), 32'h0);
        reset = 1'b0;

        // Single steps upward with zero fill.
        do_load(4'hB);
        check("load_q", 32'(q), 32'h0B);
        shift_en = 1'b1; dir = 1'b0; serial_in = 1'b0;
        repeat (3) tick();
        shift_en = 1'b0;
        check("step_q", 32'(q), 32'h58);
        check("step_so", 32'(serial_out), 32'h0);

        // Counted shift of 5 upward, fill 1.
        do_load(4'hB);
        start = 1'b1; amount = CW'(5); dir = 1'b0; serial_in = 1'b1;
        tick();
        start = 1'b0;
        bc = 0; done_at = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) tick();
            if (busy) bc++;
            if (done) begin done_at = i; break; end
        end
        check("ms5_busy_cycles", 32'(bc), 32'd5);
        check("ms5_done_cycle", 32'(done_at), 32'd6);
        check("ms5_busy_at_done", 32'(busy), 32'h0);
        check("ms5_q", 32'(q), 32'h7F);
        check("ms5_so", 32'(serial_out), 32'h1);

        // Counted shift of 2 downward, fill 0; then a zero-length request.
        do_load(4'hB);
        start = 1'b1; amount = CW'(2); dir = 1'b1; serial_in = 1'b0;
        tick();
        start = 1'b0;
        done_at = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (done) begin done_at = i; break; end
        end
        check("ms2_done_seen", 32'(done_at), 32'd2);
        check("ms2_q", 32'(q), 32'h02);
        check("ms2_so", 32'(serial_out), 32'h1);
        start = 1'b1; amount = '0;
        tick();
        start = 1'b0;
        check("ms0_done", 32'(done), 32'h1);
        check("ms0_busy", 32'(busy), 32'h0);
        check("ms0_q", 32'(q), 32'h02);
        tick();
        check("ms0_done_once", 32'(done), 32'h0);

        // Load aborts a running sequence without a done pulse.
        start = 1'b1; amount = CW'(8); dir = 1'b0; serial_in = 1'b0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("abort_busy_before", 32'(busy), 32'h1);
        do_load(4'h6);
        check("abort_q", 32'(q), 32'h06);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) saw_done = 1;
        end
        check("abort_no_done", 32'(saw_done), 32'h0);

        // Asynchronous reset in the middle of a sequence.
        start = 1'b1; amount = CW'(8); serial_in = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_q", 32'(q), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_so", 32'(serial_out), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        compare();

        // Eight-step rotate returns the loaded value; without rotate, zeros fill.
        do_load(4'h9);
        start = 1'b1; amount = CW'(8); dir = 1'b0; serial_in = 1'b0; rotate = 1'b1;
        tick();
        start = 1'b0;
        done_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin done_at = i; break; end
        end
        rotate = 1'b0;
        check("rot_done_seen", 32'(done_at), 32'd8);
`ifdef SHIFT_REG_ROTATE_EN
        check("rot_q", 32'(q), 32'h09);
`else
        check("rot_q", 32'(q), 32'h00);
`endif

        // Randomized traffic, including occasional async reset mid-cycle.
        for (int n = 0; n < 3000; n++) begin
            load      = ($urandom % 16) == 0;
            load_data = LOAD_W'($urandom);
            start     = ($urandom % 6) == 0;
            amount    = CW'($urandom_range(0, 10));
            shift_en  = ($urandom % 2) == 0;
            dir       = 1'($urandom);
            serial_in = 1'($urandom);
            rotate    = 1'($urandom);
            if (($urandom % 250) == 0) begin
                async_reset_pulse();
            end else begin
                tick();
            end
        end

        idle_inputs();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
